// File: rtl/data_mem_responder.sv
// Slow data-memory responder for the MEM-stage port: one request at a time,
// fixed latency, valid/ready response, word RAM cleared on reset.
//
// Ports:
//   i_clock, i_reset           clock, async active-high reset
//   i_req_valid / o_req_ready  request handshake
//   i_req_we, i_req_addr       1=write / byte address
//   i_req_wdata                write data
//   o_rsp_valid / i_rsp_ready  response handshake
//   o_rsp_rdata                read data (0 for writes and errors)
//   o_rsp_write, o_rsp_err     write ack / misaligned request
module data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [31:0]           i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_write,
    output logic                  o_rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LP_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]            r_cnt;
    logic                  r_we;
    logic                  r_misal;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_write;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_accept;
    logic w_access;
    logic w_ram_we;
    logic w_unused_addr;

    // Upper address bits only alias onto the RAM; they are dropped.
    assign w_unused_addr = ^i_req_addr[31:DEPTH_LOG2+2];

    assign w_accept = (r_state == S_IDLE) && i_req_valid;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_ram_we = w_access && r_we && !r_misal;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Reset is async, so keep ready low while it is held.
                o_req_ready = !i_reset;
                if (i_req_valid) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_misal     <= 1'b0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= LP_CNT_LOAD;
                r_we    <= i_req_we;
                r_misal <= |i_req_addr[1:0];
                r_index <= i_req_addr[DEPTH_LOG2+1:2];
                r_wdata <= i_req_wdata;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rsp_write <= r_we;
                r_rsp_err   <= r_misal;
                if (r_misal || r_we) begin
                    r_rsp_rdata <= '0;
                end else begin
                    r_rsp_rdata <= r_mem[r_index];
                end
            end
        end
    end

    // One register per word so the whole RAM clears on reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                r_mem[g] <= '0;
            end else if (w_ram_we && r_index == DEPTH_LOG2'(g)) begin
                r_mem[g] <= r_wdata;
            end
        end
    end

    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_write = r_rsp_write;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: main instance LATENCY=2,
// plus LATENCY=1 and LATENCY=7 instances for the latency sweep.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    int          dsel;

    logic        rdy0, rdy1, rdy7;
    logic        vld0, vld1, vld7;
    logic [31:0] rd0, rd1, rd7;
    logic        wr0, wr1, wr7;
    logic        er0, er1, er7;

    logic        m_rdy, m_vld, m_wr, m_er;
    logic [31:0] m_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(2)) u_dut (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_valid && dsel == 0), .o_req_ready(rdy0),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(vld0), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rd0), .o_rsp_write(wr0), .o_rsp_err(er0)
    );

    data_mem_responder #(.LATENCY(1)) u_l1 (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_valid && dsel == 1), .o_req_ready(rdy1),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(vld1), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rd1), .o_rsp_write(wr1), .o_rsp_err(er1)
    );

    data_mem_responder #(.LATENCY(7)) u_l7 (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_valid && dsel == 2), .o_req_ready(rdy7),
        .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(vld7), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rd7), .o_rsp_write(wr7), .o_rsp_err(er7)
    );

    always_comb begin
        m_rdy = rdy0; m_vld = vld0; m_rd = rd0; m_wr = wr0; m_er = er0;
        if (dsel == 1) begin
            m_rdy = rdy1; m_vld = vld1; m_rd = rd1; m_wr = wr1; m_er = er1;
        end else if (dsel == 2) begin
            m_rdy = rdy7; m_vld = vld7; m_rd = rd7; m_wr = wr7; m_er = er7;
        end
    end

    // Drives one transaction on the selected instance with rsp_ready=1.
    // edges: posedges from acceptance until rsp_valid is seen.
    // rdy_hi: req_ready seen high between acceptance and response.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int edges,
                           output logic [31:0] rdata, output logic wr,
                           output logic er, output bit rdy_hi,
                           output bit to);
        int k;
        to = 0; rdy_hi = 0; edges = 0;
        rdata = '0; wr = 0; er = 0;
        @(negedge clk);
        k = 0;
        while (!m_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!m_rdy) begin
            to = 1;
            return;
        end
        req_we = we; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(posedge clk);
            #1 edges++;
            if (m_rdy) rdy_hi = 1;
        end while (!m_vld && edges < 40);
        if (!m_vld) begin
            to = 1;
            return;
        end
        rdata = m_rd; wr = m_wr; er = m_er;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rdy0 !== 1'b0) begin
            n_err++; $display("FAIL rst_ready: got %b want 0", rdy0);
        end
        n_cmp++;
        if ({vld0, wr0, er0, rd0} !== 35'd0) begin
            n_err++;
            $display("FAIL rst_outputs: got v%b w%b e%b d%h want all 0",
                     vld0, wr0, er0, rd0);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== 1'b1) begin
            n_err++; $display("FAIL rst_release_ready: got %b want 1", rdy0);
        end
    endtask

    task automatic test_write_read;
        int e; logic [31:0] d; logic w, r; bit h, to;
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, e, d, w, r, h, to);
        n_cmp++;
        if (to || e != 2) begin
            n_err++; $display("FAIL wr_latency: got %0d to=%0d want 2", e, to);
        end
        n_cmp++;
        if ({w, r, d} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL wr_rsp: got w%b e%b d%h want w1 e0 d0", w, r, d);
        end
        run_txn(1'b0, 32'h10, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || {w, r, d} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL rd_after_wr: got w%b e%b d%h want w0 e0 deadbeef",
                     w, r, d);
        end
    endtask

    task automatic test_latency;
        int e; logic [31:0] d; logic w, r; bit h, to;
        int lat [3] = '{2, 1, 7};
        for (int s = 0; s < 3; s++) begin
            dsel = s;
            run_txn(1'b0, 32'h80, 32'h0, e, d, w, r, h, to);
            n_cmp++;
            if (to || e != lat[s]) begin
                n_err++;
                $display("FAIL lat_edges[%0d]: got %0d want %0d", s, e, lat[s]);
            end
            n_cmp++;
            if (d !== 32'h0 || h) begin
                n_err++;
                $display("FAIL lat_data_ready[%0d]: got d%h rdy_hi=%0d want 0/0",
                         s, d, h);
            end
        end
        dsel = 0;
    endtask

    task automatic test_backpressure;
        int e; logic [31:0] d; logic w, r; bit h, to;
        int k;
        bit bad;
        run_txn(1'b1, 32'h20, 32'h12345678, e, d, w, r, h, to);
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h55;
        k = 0;
        while (!vld0 && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        bad = !vld0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!vld0 || rd0 !== 32'h12345678 || rdy0 !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL bp_hold: got v%b d%h rdy%b want v1 12345678 rdy0",
                     vld0, rd0, rdy0);
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rdy0 !== 1'b1 || vld0 !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got rdy%b v%b want rdy1 v0", rdy0, vld0);
        end
        run_txn(1'b0, 32'h24, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || d !== 32'h0) begin
            n_err++; $display("FAIL bp_no_accept: got %h want 0", d);
        end
    endtask

    task automatic test_misaligned;
        int e; logic [31:0] d; logic w, r; bit h, to;
        run_txn(1'b1, 32'h13, 32'hFFFFFFFF, e, d, w, r, h, to);
        n_cmp++;
        if (to || {w, r, d} !== {1'b1, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL mis_wr: got w%b e%b d%h want w1 e1 d0", w, r, d);
        end
        run_txn(1'b0, 32'h11, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || {w, r, d} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL mis_rd: got w%b e%b d%h want w0 e1 d0", w, r, d);
        end
        run_txn(1'b0, 32'h10, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || {r, d} !== {1'b0, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL mis_intact: got %h want deadbeef", d);
        end
    endtask

    task automatic test_wrap;
        int e; logic [31:0] d; logic w, r; bit h, to;
        run_txn(1'b1, 32'h1000, 32'hA5A5A5A5, e, d, w, r, h, to);
        run_txn(1'b0, 32'h0, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || d !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL wrap_alias0: got %h want a5a5a5a5", d);
        end
        run_txn(1'b1, 32'hFFC, 32'h0BADF00D, e, d, w, r, h, to);
        run_txn(1'b0, 32'hFFC, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || d !== 32'h0BADF00D) begin
            n_err++; $display("FAIL wrap_top: got %h want 0badf00d", d);
        end
        run_txn(1'b0, 32'h1FFC, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || d !== 32'h0BADF00D) begin
            n_err++; $display("FAIL wrap_top_alias: got %h want 0badf00d", d);
        end
    endtask

    task automatic test_reset_abort;
        int e; logic [31:0] d; logic w, r; bit h, to;
        bit seen;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (vld0 !== 1'b0 || rdy0 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_async: got v%b rdy%b want 0/0", vld0, rdy0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy0 !== 1'b1) begin
            n_err++; $display("FAIL abort_idle: got rdy%b want 1", rdy0);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (vld0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++; $display("FAIL abort_no_rsp: got rsp seen=1 want 0");
        end
        run_txn(1'b0, 32'h40, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || d !== 32'h0) begin
            n_err++; $display("FAIL abort_no_write: got %h want 0", d);
        end
        run_txn(1'b0, 32'h10, 32'h0, e, d, w, r, h, to);
        n_cmp++;
        if (to || d !== 32'h0) begin
            n_err++; $display("FAIL abort_ram_clear: got %h want 0", d);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        dsel = 0;
        test_reset();
        test_write_read();
        test_latency();
        test_backpressure();
        test_misaligned();
        test_wrap();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data port: accepts one read/write request at a time, serves it from an internal word-addressed RAM after a fixed latency, and returns a response through a valid/ready handshake.
- Replaces the always-ready memory model so that the CPU's memory-stage stall logic can be exercised against a slow memory.
- Also serves as a standalone test target for stall handling.

Parameters:
- DATA_WIDTH, 32, width of write data and read data.
- DEPTH_LOG2, 10, log2 of the number of words in the RAM (default 1024 words).
- LATENCY, 2, number of clock edges from request acceptance to response valid; legal range 1..15.

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  responder can accept a request.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  DATA_WIDTH  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  requester accepts the response.
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and errors.
- RSP_WRITE  out  1  response acknowledges a write.
- RSP_ERR  out  1  request was misaligned; no memory access was performed.

Behaviour:

Reset (asynchronous, RESET=1):
- State goes to IDLE.
- REQ_READY=0 while RESET is high.
- RSP_VALID=0, RSP_RDATA=0, RSP_WRITE=0, RSP_ERR=0.
- Latency counter is cleared and captured request registers are cleared.
- All RAM words are cleared to 0.
- A request or response in flight is discarded; no partial write occurs.

State machine:
- States are IDLE, WAIT and RESP.
- IDLE:
  - REQ_READY=1.
  - When REQ_VALID=1 at a rising edge, the request is accepted: REQ_WE, REQ_ADDR and REQ_WDATA are captured, the counter is loaded with LATENCY-1, and the state moves to WAIT.
- WAIT:
  - REQ_READY=0.
  - The counter decrements on each edge.
  - On the edge where counter==0, the access is performed and the state moves to RESP.
- RESP:
  - REQ_READY=0, RSP_VALID=1.
  - Outputs are held stable until RSP_READY=1 at an edge.
  - On that edge the state moves to IDLE and RSP_VALID drops.
  - No same-cycle acceptance of a new request: the next request can be accepted at the earliest one edge after response completion.

Latency:
- If the request is accepted at edge E0, RSP_VALID is 1 in the cycle after edge E0+LATENCY.
- With LATENCY=2 and RSP_READY held at 1, one transaction takes 4 cycles, IDLE to IDLE.

Access rules:
- Word index = REQ_ADDR[DEPTH_LOG2+1:2].
- Upper address bits are ignored, so addresses beyond the RAM size alias by wrap-around.
- Misaligned requests (REQ_ADDR[1:0]!=0):
  - No RAM read or write.
  - RSP_ERR=1, RSP_RDATA=0.
  - RSP_WRITE reflects the captured REQ_WE.
- Aligned write: RAM[index] is updated at the access edge; RSP_WRITE=1, RSP_RDATA=0, RSP_ERR=0.
- Aligned read: RSP_RDATA = RAM[index] as sampled at the access edge; RSP_WRITE=0, RSP_ERR=0.
- Request inputs are ignored outside IDLE; a requester holding REQ_VALID is simply not accepted.

Boundary cases:
- Read immediately after a write to the same address returns the new data (serialized transactions).
- Highest word index (2^DEPTH_LOG2-1) is accessible.
- Address 4*2^DEPTH_LOG2 aliases to index 0.
- RESET asserted in any state aborts to IDLE within the same cycle, without waiting for a clock edge.

Test Plan:
1. Reset, then write REQ_ADDR=0x10 with data 0xDEADBEEF -> REQ_READY=1 after reset deasserts; RSP_VALID after edge E0+2 with RSP_WRITE=1, RSP_ERR=0, RSP_RDATA=0. Then read 0x10 -> RSP_RDATA=0xDEADBEEF, RSP_WRITE=0.
2. Latency sweep with LATENCY=1, 2 and 7: read of an unwritten address -> RSP_VALID rises exactly LATENCY edges after acceptance; RSP_RDATA=0; REQ_READY=0 throughout WAIT and RESP.
3. Backpressure: RSP_READY held at 0 for 5 cycles during a read of 0x20 (holding 0x12345678) -> RSP_VALID and RSP_RDATA stay 0x12345678 and are stable; a second REQ_VALID is not accepted; REQ_READY returns 1 one edge after RSP_READY=1.
4. Misaligned write to 0x13 with data 0xFFFFFFFF -> RSP_ERR=1, RSP_WRITE=1; a subsequent read of 0x10 still returns the prior value 0xDEADBEEF.
5. Wrap-around with DEPTH_LOG2=10: write 0xA5A5A5A5 to 0x1000, then read 0x0 -> RSP_RDATA=0xA5A5A5A5. Write to 0xFFC and read it back -> value preserved.
6. RESET pulse during WAIT of a write to 0x40 -> RSP_VALID=0 and state IDLE immediately; a subsequent read of 0x40 returns 0; no response from the aborted request is ever seen.
